// File: rtl/rgmii_tx_mac_if.sv
// RGMII transmit front end: MAC byte stream to registered rising/falling ODDR pairs,
// 1G byte or 10/100 nibble mode, IPG enforcement, TX_ER on underrun. Optional pad: RGMII_TX_PAD_EN.
module rgmii_tx_mac_if #(
    parameter int IPG_BYTES       = 12,
    parameter int MIN_FRAME_BYTES = 60,
    parameter int CNT_W           = 16
) (
    input  logic             gmii_tx_clk,
    input  logic             rst_n,
    input  logic             speed_1g,
    input  logic [7:0]       tx_data,
    input  logic             tx_valid,
    input  logic             tx_last,
    output logic             tx_ready,
    output logic [3:0]       txd_r,
    output logic [3:0]       txd_f,
    output logic             ctl_r,
    output logic             ctl_f,
    output logic             tx_busy,
    output logic             underrun,
    output logic [CNT_W-1:0] frame_cnt
);

    if (IPG_BYTES < 1 || IPG_BYTES > 255) begin : g_bad_ipg
        $error("IPG_BYTES out of range 1..255");
    end
    if (MIN_FRAME_BYTES < 1 || MIN_FRAME_BYTES > 255) begin : g_bad_min
        $error("MIN_FRAME_BYTES out of range 1..255");
    end

    // IDLE supplies the final idle byte-time, so IPG itself runs one byte-time short.
    localparam logic [8:0]       IPG_1G = 9'(IPG_BYTES - 1);
    localparam logic [8:0]       IPG_NB = 9'(2 * IPG_BYTES - 1);
    localparam logic [CNT_W-1:0] ONE    = 1;
`ifdef RGMII_TX_PAD_EN
    localparam logic [7:0]       MIN_LEN = 8'(MIN_FRAME_BYTES);
`endif

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_DATA = 3'd1,
        S_IPG  = 3'd2,
        S_DROP = 3'd3
`ifdef RGMII_TX_PAD_EN
        , S_PAD = 3'd4
`endif
    } state_t;

    state_t           state_q, state_d;
    logic             mode_q, mode_d, phase_q, phase_d, last_q, last_d, hold_q, hold_d;
    logic [7:0]       byte_q, byte_d, len_q, len_d;
    logic [8:0]       ipg_q, ipg_d;
    logic [3:0]       txd_r_q, txd_r_d, txd_f_q, txd_f_d;
    logic             ctl_r_q, ctl_r_d, ctl_f_q, ctl_f_d, urun_q, urun_d;
    logic             rdy_q, rdy_d, busy_q;
    logic [CNT_W-1:0] fcnt_q, fcnt_d;

    logic       accept, slot, load_byte, end_frame, to_ipg;
    logic [7:0] len_inc;
    logic [8:0] ipg_load;

    assign accept   = tx_valid && rdy_q;
    // slot = cycle in which a byte boundary falls: every 1G cycle, nibble phase 1
    assign slot     = mode_q | phase_q;
    assign len_inc  = (len_q == 8'hFF) ? len_q : len_q + 8'd1;
    assign ipg_load = mode_q ? IPG_1G : IPG_NB;

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        phase_d   = phase_q;
        last_d    = last_q;
        byte_d    = byte_q;
        len_d     = len_q;
        ipg_d     = ipg_q;
        hold_d    = 1'b0;
        fcnt_d    = fcnt_q;
        txd_r_d   = '0;
        txd_f_d   = '0;
        ctl_r_d   = 1'b0;
        ctl_f_d   = 1'b0;
        urun_d    = 1'b0;
        load_byte = 1'b0;
        end_frame = 1'b0;
        to_ipg    = 1'b0;
        case (state_q)
            S_IDLE: if (accept) begin
                mode_d    = speed_1g;
                len_d     = 8'd1;
                load_byte = 1'b1;
                state_d   = S_DATA;
            end
            S_DATA: begin
                if (!slot) begin
                    phase_d = 1'b1;
                    txd_r_d = byte_q[7:4];
                    txd_f_d = byte_q[7:4];
                    ctl_r_d = 1'b1;
                    ctl_f_d = 1'b1;
                end else if (last_q) begin
`ifdef RGMII_TX_PAD_EN
                    if (len_q < MIN_LEN) begin
                        state_d = S_PAD;
                        phase_d = 1'b0;
                        len_d   = len_inc;
                        ctl_r_d = 1'b1;
                        ctl_f_d = 1'b1;
                    end else
`endif
                    end_frame = 1'b1;
                end else if (accept) begin
                    load_byte = 1'b1;
                    len_d     = len_inc;
                end else begin
                    // underrun: one TX_ER byte-time, then discard the rest of the frame
                    urun_d  = 1'b1;
                    ctl_r_d = 1'b1;
                    hold_d  = ~mode_q;
                    state_d = S_DROP;
                end
            end
`ifdef RGMII_TX_PAD_EN
            S_PAD: begin
                if (!slot) begin
                    phase_d = 1'b1;
                    ctl_r_d = 1'b1;
                    ctl_f_d = 1'b1;
                end else if (len_q >= MIN_LEN) begin
                    end_frame = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    len_d   = len_inc;
                    ctl_r_d = 1'b1;
                    ctl_f_d = 1'b1;
                end
            end
`endif
            S_IPG: begin
                if (ipg_q <= 9'd1) begin
                    state_d = S_IDLE;
                    ipg_d   = '0;
                end else begin
                    ipg_d = ipg_q - 9'd1;
                end
            end
            S_DROP: begin
                ctl_r_d = hold_q;
                if (accept && tx_last) to_ipg = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        if (load_byte) begin
            byte_d  = tx_data;
            last_d  = tx_last;
            phase_d = 1'b0;
            txd_r_d = tx_data[3:0];
            txd_f_d = mode_d ? tx_data[7:4] : tx_data[3:0];
            ctl_r_d = 1'b1;
            ctl_f_d = 1'b1;
        end
        if (end_frame) begin
            fcnt_d = fcnt_q + ONE;
            to_ipg = 1'b1;
        end
        if (to_ipg) begin
            state_d = (ipg_load == 9'd0) ? S_IDLE : S_IPG;
            ipg_d   = ipg_load;
        end

        case (state_d)
            S_IDLE:  rdy_d = 1'b1;
            S_DATA:  rdy_d = (mode_d | phase_d) && !last_d;
            S_DROP:  rdy_d = 1'b1;
            default: rdy_d = 1'b0;
        endcase
    end

    always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            mode_q  <= 1'b0;
            phase_q <= 1'b0;
            last_q  <= 1'b0;
            hold_q  <= 1'b0;
            byte_q  <= '0;
            len_q   <= '0;
            ipg_q   <= '0;
            txd_r_q <= '0;
            txd_f_q <= '0;
            ctl_r_q <= 1'b0;
            ctl_f_q <= 1'b0;
            urun_q  <= 1'b0;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            phase_q <= phase_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
            byte_q  <= byte_d;
            len_q   <= len_d;
            ipg_q   <= ipg_d;
            txd_r_q <= txd_r_d;
            txd_f_q <= txd_f_d;
            ctl_r_q <= ctl_r_d;
            ctl_f_q <= ctl_f_d;
            urun_q  <= urun_d;
            rdy_q   <= rdy_d;
            busy_q  <= (state_d != S_IDLE);
            fcnt_q  <= fcnt_d;
        end
    end

    assign tx_ready  = rdy_q;
    assign txd_r     = txd_r_q;
    assign txd_f     = txd_f_q;
    assign ctl_r     = ctl_r_q;
    assign ctl_f     = ctl_f_q;
    assign tx_busy   = busy_q;
    assign underrun  = urun_q;
    assign frame_cnt = fcnt_q;

endmodule

// File: tb/tb_rgmii_tx_mac_if.sv
// Directed bench for rgmii_tx_mac_if: byte/nibble framing, IPG length, underrun, padding, reset.
module tb_rgmii_tx_mac_if;

    logic        gmii_tx_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        speed_1g = 1'b1;
    logic [7:0]  tx_data = '0;
    logic        tx_valid = 1'b0;
    logic        tx_last = 1'b0;
    logic        tx_ready;
    logic [3:0]  txd_r, txd_f;
    logic        ctl_r, ctl_f, tx_busy, underrun;
    logic [15:0] frame_cnt;

    int nchk = 0;
    int nerr = 0;

    always #5 gmii_tx_clk = ~gmii_tx_clk;

    rgmii_tx_mac_if dut (
        .gmii_tx_clk(gmii_tx_clk), .rst_n(rst_n), .speed_1g(speed_1g),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last), .tx_ready(tx_ready),
        .txd_r(txd_r), .txd_f(txd_f), .ctl_r(ctl_r), .ctl_f(ctl_f),
        .tx_busy(tx_busy), .underrun(underrun), .frame_cnt(frame_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge gmii_tx_clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        tx_data  = d;
        tx_last  = l;
        tx_valid = 1'b1;
        step();
    endtask

    // steps until tx_ready rises; n = number of steps taken
    task automatic wait_rdy(output int n);
        n = 0;
        while (!tx_ready && n < 200) begin
            step();
            n++;
        end
        if (!tx_ready) chk("rdy_timeout", {31'd0, tx_ready}, 32'd1);
    endtask

    task automatic chk_out(input string tag, input logic [3:0] r, input logic [3:0] f,
                           input logic cr, input logic cf);
        chk({tag, "_r"}, {28'd0, txd_r}, {28'd0, r});
        chk({tag, "_f"}, {28'd0, txd_f}, {28'd0, f});
        chk({tag, "_ctl"}, {30'd0, ctl_r, ctl_f}, {30'd0, cr, cf});
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n, cnt, g, exp_len;
        logic [7:0] b;

        // reset state
        #23;
        chk("rst_out", {txd_r, txd_f, 2'b0, ctl_r, ctl_f}, 32'd0);
        chk("rst_flags", {29'd0, tx_ready, tx_busy, underrun}, 32'd0);
        chk("rst_fcnt", {16'd0, frame_cnt}, 32'd0);
        rst_n = 1'b1;
        step();
        chk("idle_rdy", {31'd0, tx_ready}, 32'd1);

        // 1) 1G, 55 D5 A1 3C
        speed_1g = 1'b1;
        send(8'h55, 1'b0); chk_out("t1b0", 4'h5, 4'h5, 1'b1, 1'b1);
        chk("t1_busy", {31'd0, tx_busy}, 32'd1);
        send(8'hD5, 1'b0); chk_out("t1b1", 4'h5, 4'hD, 1'b1, 1'b1);
        send(8'hA1, 1'b0); chk_out("t1b2", 4'h1, 4'hA, 1'b1, 1'b1);
        send(8'h3C, 1'b1); chk_out("t1b3", 4'hC, 4'h3, 1'b1, 1'b1);
        tx_valid = 1'b0; tx_last = 1'b0;
        chk("t1_rdy_last", {31'd0, tx_ready}, 32'd0);
        step();
        chk_out("t1ipg", 4'h0, 4'h0, 1'b0, 1'b0);
        chk("t1_fcnt", {16'd0, frame_cnt}, 32'd1);
        wait_rdy(n);
        chk("t1_gap", n, 32'd11);

        // 2) nibble, A7 then 3C(last)
        speed_1g = 1'b0;
        send(8'hA7, 1'b0); chk_out("t2n0", 4'h7, 4'h7, 1'b1, 1'b1);
        chk("t2_rdy_ph0", {31'd0, tx_ready}, 32'd0);
        tx_data = 8'h3C; tx_last = 1'b1;
        step(); chk_out("t2n1", 4'hA, 4'hA, 1'b1, 1'b1);
        chk("t2_rdy_ph1", {31'd0, tx_ready}, 32'd1);
        step(); chk_out("t2n2", 4'hC, 4'hC, 1'b1, 1'b1);
        tx_valid = 1'b0; tx_last = 1'b0;
        chk("t2_rdy_ph0b", {31'd0, tx_ready}, 32'd0);
        step(); chk_out("t2n3", 4'h3, 4'h3, 1'b1, 1'b1);
        chk("t2_rdy_last", {31'd0, tx_ready}, 32'd0);
        wait_rdy(n);
        chk("t2_gap", n, 32'd24);
        chk("t2_fcnt", {16'd0, frame_cnt}, 32'd2);

        // 3) 1G underrun after byte 3 of 10
        speed_1g = 1'b1;
        send(8'h10, 1'b0);
        send(8'h11, 1'b0);
        send(8'h12, 1'b0); chk_out("t3b2", 4'h2, 4'h1, 1'b1, 1'b1);
        tx_valid = 1'b0;
        step();
        chk_out("t3err", 4'h0, 4'h0, 1'b1, 1'b0);
        chk("t3_urun", {31'd0, underrun}, 32'd1);
        for (int i = 3; i < 10; i++) begin
            send(8'h10 + 8'(i), i == 9);
            chk("t3_drop_ctl", {30'd0, ctl_r, ctl_f}, 32'd0);
            chk("t3_urun_low", {31'd0, underrun}, 32'd0);
        end
        tx_valid = 1'b0; tx_last = 1'b0;
        chk("t3_fcnt", {16'd0, frame_cnt}, 32'd2);
        wait_rdy(n);

        // 4) back-to-back, speed toggled mid-frame
        speed_1g = 1'b1;
        send(8'h11, 1'b0); chk_out("t4a0", 4'h1, 4'h1, 1'b1, 1'b1);
        speed_1g = 1'b0;
        send(8'h21, 1'b1); chk_out("t4a1", 4'h1, 4'h2, 1'b1, 1'b1);
        tx_data = 8'h43; tx_last = 1'b0;
        g = 0;
        do begin
            step();
            g++;
        end while (!ctl_r && g < 100);
        chk("t4_gap", g - 1, 32'd12);
        chk_out("t4b0", 4'h3, 4'h3, 1'b1, 1'b1);
        tx_data = 8'h65; tx_last = 1'b1;
        step(); chk_out("t4b1", 4'h4, 4'h4, 1'b1, 1'b1);
        step(); chk_out("t4b2", 4'h5, 4'h5, 1'b1, 1'b1);
        tx_valid = 1'b0; tx_last = 1'b0;
        step(); chk_out("t4b3", 4'h6, 4'h6, 1'b1, 1'b1);
        wait_rdy(n);
        chk("t4_gap_nib", n, 32'd24);
        chk("t4_fcnt", {16'd0, frame_cnt}, 32'd4);

        // 5) 10-byte 1G frame, padded or not
`ifdef RGMII_TX_PAD_EN
        exp_len = 60;
`else
        exp_len = 10;
`endif
        speed_1g = 1'b1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            b = 8'h80 + 8'(i);
            send(b, i == 9);
            if (ctl_r) cnt++;
        end
        tx_valid = 1'b0; tx_last = 1'b0;
        g = 0;
        do begin
            step();
            if (ctl_r) begin
                cnt++;
                if (txd_r != 4'h0) chk("t5_pad_zero", {28'd0, txd_r}, 32'd0);
            end
            g++;
        end while (ctl_r && g < 200);
        chk("t5_len", cnt, exp_len);
        chk("t5_fcnt", {16'd0, frame_cnt}, 32'd5);
        wait_rdy(n);
        chk("t5_gap", n, 32'd11);

        // 6) reset mid-frame in nibble mode
        speed_1g = 1'b0;
        send(8'h9B, 1'b0); chk_out("t6n0", 4'hB, 4'hB, 1'b1, 1'b1);
        tx_data = 8'h5A;
        step(); chk_out("t6n1", 4'h9, 4'h9, 1'b1, 1'b1);
        step(); chk_out("t6n2", 4'hA, 4'hA, 1'b1, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_out", {txd_r, txd_f, 2'b0, ctl_r, ctl_f}, 32'd0);
        chk("t6_rst_flags", {29'd0, tx_ready, tx_busy, underrun}, 32'd0);
        chk("t6_rst_fcnt", {16'd0, frame_cnt}, 32'd0);
        tx_valid = 1'b0;
        step(); step();
        chk("t6_rst_urun", {31'd0, underrun}, 32'd0);
        rst_n = 1'b1;
        step();
        chk("t6_idle", {30'd0, tx_ready, tx_busy}, 32'd2);
        speed_1g = 1'b1;
        send(8'hC4, 1'b1); chk_out("t6new", 4'h4, 4'hC, 1'b1, 1'b1);
        tx_valid = 1'b0; tx_last = 1'b0;
        chk("t6_urun", {31'd0, underrun}, 32'd0);
        wait_rdy(n);
        chk("t6_gap", n, 32'd12);
        chk("t6_fcnt", {16'd0, frame_cnt}, 32'd1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/rgmii_tx_mac_if.md
Name: rgmii_tx_mac_if

Overview:
Speed-adaptive transmit front end between the MAC byte stream and the RGMII DDR output cells. It accepts bytes with a valid/ready handshake and runs in two modes: 1000 Mb/s (8 bits per clock, split across edges) or 10/100 nibble mode (one byte over two clocks). It enforces inter-frame gap, flags underrun with TX_ER coding, and drives registered rising/falling-edge data pairs into external ODDR primitives.

Parameters:
IPG_BYTES, 12, minimum idle byte-times between frames (range 1..255).
MIN_FRAME_BYTES, 60, minimum frame length used by the padding feature (range 1..255).
CNT_W, 16, width of the frame counter.

Ports:
gmii_tx_clk  in  1  transmit clock (125 / 25 / 2.5 MHz).
rst_n  in  1  asynchronous active-low reset.
speed_1g  in  1  1 = byte mode, 0 = nibble mode; sampled only in IDLE.
tx_data  in  8  byte from MAC.
tx_valid  in  1  tx_data valid.
tx_last  in  1  final byte of frame, qualified by tx_valid.
tx_ready  out  1  byte accepted when tx_valid && tx_ready.
txd_r  out  4  data for the rising-edge ODDR input.
txd_f  out  4  data for the falling-edge ODDR input.
ctl_r  out  1  TX_EN for the rising edge.
ctl_f  out  1  TX_EN xor TX_ER for the falling edge.
tx_busy  out  1  state is not IDLE.
underrun  out  1  one-cycle pulse when a mid-frame underrun is detected.
frame_cnt  out  CNT_W  frames completed without underrun; wraps at 2^CNT_W.

Behaviour:
- Reset: all outputs 0, state IDLE, IPG counter 0 (first frame may start immediately).
- All outputs are registered. A byte accepted in cycle N appears on the outputs in cycle N+1.
- States: IDLE, DATA, PAD, IPG, DROP.
- IDLE
  - tx_ready = 1.
  - On accept: latch the speed mode, go to DATA, length counter = 1.
  - If tx_last is also set, it is a 1-byte frame.
- DATA, 1G mode
  - tx_ready = 1 every cycle.
  - Outputs: txd_r = byte[3:0], txd_f = byte[7:4], ctl_r = ctl_f = 1.
- DATA, nibble mode
  - phase 0 outputs byte[3:0]; phase 1 outputs byte[7:4]. Each phase drives txd_r = txd_f = the nibble.
  - tx_ready = 1 only during the phase-1 cycle, so one byte is accepted every 2 clocks.
- Underrun
  - Condition: in DATA, tx_ready = 1, tx_valid = 0, and the last accepted byte did not carry tx_last.
  - Next cycle: ctl_r = 1, ctl_f = 0 (TX_ER), txd = 0; nibble mode holds this for 2 cycles.
  - underrun pulses for one cycle, then state goes to DROP.
- DROP
  - tx_ready = 1, ctl = 0, accepted bytes discarded.
  - Accepting a byte with tx_last moves to IPG.
  - frame_cnt is not incremented.
- End of frame: after the byte carrying tx_last has been output (or PAD finishes), go to IPG and increment frame_cnt.
- IPG
  - ctl_r = ctl_f = 0, txd = 0, tx_ready = 0.
  - Holds IPG_BYTES byte-times: IPG_BYTES cycles in 1G mode, 2*IPG_BYTES cycles in nibble mode. Then IDLE.
- Back-to-back: tx_valid held high across frames gives exactly IPG_BYTES idle byte-times between frames.
- speed_1g changes outside IDLE are ignored until the next frame start.
- Length counter saturates at 255.
- Asynchronous reset mid-frame: outputs drop to 0 immediately. No TX_ER is emitted.

Optional Feature:
Macro RGMII_TX_PAD_EN.
- Defined: if tx_last is output with length counter < MIN_FRAME_BYTES, go to PAD. PAD emits 0x00 bytes with ctl = 1 until MIN_FRAME_BYTES bytes have been sent, then IPG. tx_ready = 0 in PAD.
- Undefined: PAD state and length-compare logic are absent; frames of any length pass unmodified.

Test Plan:
1. 1G mode, 4-byte frame 0x55,0xD5,0xA1,0x3C, tx_valid continuous.
   - txd_r/txd_f = 5/5, 5/D, 1/A, C/3 on cycles N+1..N+4; ctl_r = ctl_f = 1.
   - Then exactly 12 cycles of ctl = 0 (default IPG_BYTES, no pad). frame_cnt = 1.
2. Nibble mode, byte 0xA7 then 0x3C(last).
   - Output sequence 7,7 / A,A / C,C / 3,3.
   - tx_ready high only every 2nd cycle inside the frame; IPG lasts 24 cycles.
3. 1G mode, tx_valid dropped after byte 3 of a 10-byte frame.
   - One cycle ctl_r = 1, ctl_f = 0, underrun pulse.
   - Remaining bytes are swallowed until tx_last; frame_cnt unchanged.
4. Two frames offered back-to-back with IPG_BYTES = 12.
   - Second frame's first byte is accepted on cycle 13 after the first frame ends.
   - speed_1g toggled mid-frame has no effect until the next frame start.
5. With RGMII_TX_PAD_EN, 1G mode, 10-byte frame: 50 bytes of 0x00 follow with ctl = 1, for 60 total. Without the macro, ctl falls after 10 bytes.
6. Assert rst_n = 0 mid-frame in nibble mode: all outputs 0 at once, no underrun pulse. After release, tx_ready = 1 in IDLE and a new frame starts cleanly.
